// File: rtl/issue_layer_sequencer.sv
// Walks one Issue instance through a host-written table of per-layer convolution configs.
// Optional ISSUE_SEQ_PERF_EN adds a per-layer RUN-cycle counter (layer_cycles / layer_cycles_valid).
module issue_layer_sequencer #(
  parameter int MAX_LAYERS  = 8,
  parameter int LAYER_IDX_W = 3,
  parameter int RST_HOLD    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_wr_en,
  input  logic [LAYER_IDX_W-1:0] cfg_wr_addr,
  input  logic [21:0]            cfg_wr_data,
  input  logic [LAYER_IDX_W:0]   num_layers,
  input  logic                   start,
  input  logic                   abort,
  output logic [7:0]             issue_image_dim,
  output logic [8:0]             issue_image_depth,
  output logic [1:0]             issue_filter_halfsize,
  output logic [2:0]             issue_filter_stride,
  output logic                   issue_rst,
  input  logic                   issue_done,
  output logic [LAYER_IDX_W-1:0] layer_idx,
  output logic                   busy,
  output logic                   all_done,
  output logic                   cfg_err
`ifdef ISSUE_SEQ_PERF_EN
  ,
  output logic [31:0]            layer_cycles,
  output logic                   layer_cycles_valid
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RESET,
    S_RUN,
    S_NEXT,
    S_FINISH
  } state_t;

  state_t                 state_q;
  logic [21:0]            table_q [MAX_LAYERS];
  logic [LAYER_IDX_W:0]   num_layers_q;
  logic [LAYER_IDX_W-1:0] layer_idx_q;
  logic [3:0]             hold_cnt_q;
  logic [7:0]             dim_q;
  logic [8:0]             depth_q;
  logic [1:0]             halfsize_q;
  logic [2:0]             stride_q;
  logic                   all_done_q;
  logic                   cfg_err_q;

  // The table is deliberately outside the reset domain so a run can be replayed after rst.
  always_ff @(posedge clk) begin
    if (cfg_wr_en && (32'(cfg_wr_addr) < MAX_LAYERS)) begin
      table_q[cfg_wr_addr] <= cfg_wr_data;
    end
  end

  // Combinational read; a same-cycle write lands at the edge, so LOAD sees the old entry.
  logic [21:0] ld_entry;
  logic [7:0]  ld_dim;
  logic [8:0]  ld_depth;
  assign ld_entry = table_q[layer_idx_q];
  assign ld_dim   = ld_entry[21:14];
  assign ld_depth = ld_entry[13:5];

`ifdef ISSUE_SEQ_PERF_EN
  logic [31:0] cyc_cnt_q;
  logic        cyc_vld_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      num_layers_q <= '0;
      layer_idx_q  <= '0;
      hold_cnt_q   <= '0;
      dim_q        <= '0;
      depth_q      <= '0;
      halfsize_q   <= '0;
      stride_q     <= '0;
      all_done_q   <= 1'b0;
      cfg_err_q    <= 1'b0;
`ifdef ISSUE_SEQ_PERF_EN
      cyc_cnt_q    <= '0;
      cyc_vld_q    <= 1'b0;
`endif
    end else begin
      all_done_q <= 1'b0;
      cfg_err_q  <= 1'b0;
`ifdef ISSUE_SEQ_PERF_EN
      cyc_vld_q  <= 1'b0;
`endif
      if (abort) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              if ((num_layers != '0) && (32'(num_layers) <= MAX_LAYERS)) begin
                num_layers_q <= num_layers;
                layer_idx_q  <= '0;
                state_q      <= S_LOAD;
              end else begin
                cfg_err_q <= 1'b1;
              end
            end
          end
          S_LOAD: begin
            dim_q      <= ld_dim;
            depth_q    <= ld_depth;
            halfsize_q <= ld_entry[4:3];
            stride_q   <= ld_entry[2:0];
            // Issue cannot handle an empty volume or an image smaller than 13 pixels.
            if ((ld_depth == '0) || (ld_dim < 8'd13)) begin
              cfg_err_q <= 1'b1;
              state_q   <= S_IDLE;
            end else begin
              hold_cnt_q <= '0;
              state_q    <= S_RESET;
            end
          end
          S_RESET: begin
            if (hold_cnt_q == 4'(RST_HOLD - 1)) begin
              state_q <= S_RUN;
`ifdef ISSUE_SEQ_PERF_EN
              cyc_cnt_q <= '0;
`endif
            end else begin
              hold_cnt_q <= hold_cnt_q + 4'd1;
            end
          end
          S_RUN: begin
`ifdef ISSUE_SEQ_PERF_EN
            if (cyc_cnt_q != '1) begin
              cyc_cnt_q <= cyc_cnt_q + 32'd1;
            end
`endif
            if (issue_done) begin
              state_q <= S_NEXT;
`ifdef ISSUE_SEQ_PERF_EN
              cyc_vld_q <= 1'b1;
`endif
            end
          end
          S_NEXT: begin
            if ({1'b0, layer_idx_q} == (num_layers_q - (LAYER_IDX_W+1)'(1))) begin
              all_done_q <= 1'b1;
              state_q    <= S_FINISH;
            end else begin
              layer_idx_q <= layer_idx_q + LAYER_IDX_W'(1);
              state_q     <= S_LOAD;
            end
          end
          S_FINISH: begin
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign issue_rst             = (state_q != S_RUN);
  assign busy                  = (state_q != S_IDLE);
  assign issue_image_dim       = dim_q;
  assign issue_image_depth     = depth_q;
  assign issue_filter_halfsize = halfsize_q;
  assign issue_filter_stride   = stride_q;
  assign layer_idx             = layer_idx_q;
  assign all_done              = all_done_q;
  assign cfg_err               = cfg_err_q;

`ifdef ISSUE_SEQ_PERF_EN
  assign layer_cycles       = cyc_cnt_q;
  assign layer_cycles_valid = cyc_vld_q;
`endif

endmodule

// File: tb/tb_issue_layer_sequencer.sv
// Directed bench for issue_layer_sequencer with hand-computed expectations (default parameters).
module tb_issue_layer_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_wr_en;
  logic [2:0]  cfg_wr_addr;
  logic [21:0] cfg_wr_data;
  logic [3:0]  num_layers;
  logic        start;
  logic        abort;
  logic [7:0]  issue_image_dim;
  logic [8:0]  issue_image_depth;
  logic [1:0]  issue_filter_halfsize;
  logic [2:0]  issue_filter_stride;
  logic        issue_rst;
  logic        issue_done;
  logic [2:0]  layer_idx;
  logic        busy;
  logic        all_done;
  logic        cfg_err;
`ifdef ISSUE_SEQ_PERF_EN
  logic [31:0] layer_cycles;
  logic        layer_cycles_valid;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  issue_layer_sequencer dut (
    .clk                   (clk),
    .rst                   (rst),
    .cfg_wr_en             (cfg_wr_en),
    .cfg_wr_addr           (cfg_wr_addr),
    .cfg_wr_data           (cfg_wr_data),
    .num_layers            (num_layers),
    .start                 (start),
    .abort                 (abort),
    .issue_image_dim       (issue_image_dim),
    .issue_image_depth     (issue_image_depth),
    .issue_filter_halfsize (issue_filter_halfsize),
    .issue_filter_stride   (issue_filter_stride),
    .issue_rst             (issue_rst),
    .issue_done            (issue_done),
    .layer_idx             (layer_idx),
    .busy                  (busy),
    .all_done              (all_done),
    .cfg_err               (cfg_err)
`ifdef ISSUE_SEQ_PERF_EN
    ,
    .layer_cycles          (layer_cycles),
    .layer_cycles_valid    (layer_cycles_valid)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [21:0] pack(input int dim, input int depth, input int hs, input int st);
    return {8'(dim), 9'(depth), 2'(hs), 3'(st)};
  endfunction

  task automatic wr(input int addr, input logic [21:0] data);
    cfg_wr_en   = 1'b1;
    cfg_wr_addr = 3'(addr);
    cfg_wr_data = data;
    tick();
    cfg_wr_en   = 1'b0;
  endtask

  task automatic do_start(input int n);
    num_layers = 4'(n);
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_run(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (!issue_rst) break;
      tick();
    end
    check(tag, 32'(issue_rst), 32'd0);
  endtask

  task automatic complete_run(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      issue_done = !issue_rst;
      tick();
    end
    issue_done = 1'b0;
    check(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;
    num_layers = '0; start = 1'b0; abort = 1'b0; issue_done = 1'b0;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_issue_rst", 32'(issue_rst), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dim", 32'(issue_image_dim), 32'd0);
    check("rst_depth", 32'(issue_image_depth), 32'd0);
    check("rst_hs_st", {issue_filter_halfsize, issue_filter_stride}, 32'd0);
    check("rst_idx", 32'(layer_idx), 32'd0);
    check("rst_pulses", {all_done, cfg_err}, 32'd0);
`ifdef ISSUE_SEQ_PERF_EN
    check("rst_perf", layer_cycles, 32'd0);
    check("rst_perf_vld", 32'(layer_cycles_valid), 32'd0);
`endif

    // Rejected starts: 0 and 9 layers
    do_start(0);
    check("nl0_err", 32'(cfg_err), 32'd1);
    check("nl0_busy", 32'(busy), 32'd0);
    tick();
    check("nl0_err_pulse", 32'(cfg_err), 32'd0);
    do_start(9);
    check("nl9_err", 32'(cfg_err), 32'd1);
    check("nl9_busy", 32'(busy), 32'd0);

    // Two-layer run with exact latency
    wr(0, pack(224, 3, 2, 4));
    wr(1, pack(56, 96, 1, 1));
    do_start(2);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_cfg_err", 32'(cfg_err), 32'd0);
    tick();
    check("t2_dim", 32'(issue_image_dim), 32'd224);
    check("t2_depth", 32'(issue_image_depth), 32'd3);
    check("t2_hs_st", {issue_filter_halfsize, issue_filter_stride}, {2'd2, 3'd4});
    check("t2_issue_rst", 32'(issue_rst), 32'd1);
    tick();
    check("t3_issue_rst", 32'(issue_rst), 32'd1);
    tick();
    check("t4_issue_rst", 32'(issue_rst), 32'd0);
    // start while busy: ignored, no error
    start = 1'b1; num_layers = 4'd0;
    tick();
    start = 1'b0;
    check("busy_start_err", 32'(cfg_err), 32'd0);
    check("busy_start_run", 32'(issue_rst), 32'd0);
    issue_done = 1'b1;
    tick();
    issue_done = 1'b0;
    check("next_issue_rst", 32'(issue_rst), 32'd1);
    tick();
    check("l1_idx", 32'(layer_idx), 32'd1);
    tick();
    check("l1_dim", 32'(issue_image_dim), 32'd56);
    check("l1_depth", 32'(issue_image_depth), 32'd96);
    tick(); tick();
    check("l1_run", 32'(issue_rst), 32'd0);
    issue_done = 1'b1;
    tick();
    issue_done = 1'b0;
    check("l1_next_no_done", 32'(all_done), 32'd0);
    tick();
    check("all_done", 32'(all_done), 32'd1);
    tick();
    check("all_done_pulse", 32'(all_done), 32'd0);
    check("end_busy", 32'(busy), 32'd0);
    check("end_idx_hold", 32'(layer_idx), 32'd1);

    // Abort during layer-0 RUN, then restart
    do_start(2);
    check("restart_idx", 32'(layer_idx), 32'd0);
    wait_run("abort_run");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_issue_rst", 32'(issue_rst), 32'd1);
    check("abort_pulses", {all_done, cfg_err}, 32'd0);
    // start together with abort is dropped
    start = 1'b1; abort = 1'b1; num_layers = 4'd2;
    tick();
    start = 1'b0; abort = 1'b0;
    check("start_abort", 32'(busy), 32'd0);
    do_start(2);
    tick();
    check("fresh_idx", 32'(layer_idx), 32'd0);
    check("fresh_dim", 32'(issue_image_dim), 32'd224);
    complete_run("fresh_end");

    // Bad layer configs: dim=12, depth=0; dim=13 is the smallest legal image
    wr(0, pack(12, 5, 1, 1));
    do_start(1);
    tick();
    check("dim12_err", 32'(cfg_err), 32'd1);
    check("dim12_busy", 32'(busy), 32'd0);
    check("dim12_issue_rst", 32'(issue_rst), 32'd1);
    wr(0, pack(224, 0, 2, 4));
    do_start(1);
    tick();
    check("depth0_err", 32'(cfg_err), 32'd1);
    check("depth0_busy", 32'(busy), 32'd0);
    tick();
    check("depth0_issue_rst", 32'(issue_rst), 32'd1);
    wr(0, pack(13, 1, 0, 1));
    do_start(1);
    tick();
    check("dim13_ok", 32'(cfg_err), 32'd0);
    wait_run("dim13_run");
    complete_run("dim13_end");

    // Rewrite entry 1 while layer 0 runs
    wr(0, pack(224, 3, 2, 4));
    do_start(2);
    wait_run("rw_run");
    wr(1, pack(80, 16, 3, 2));
    issue_done = 1'b1;
    tick();
    issue_done = 1'b0;
    tick();
    tick();
    check("rw_dim", 32'(issue_image_dim), 32'd80);
    check("rw_depth", 32'(issue_image_depth), 32'd16);
    check("rw_hs_st", {issue_filter_halfsize, issue_filter_stride}, {2'd3, 3'd2});
    complete_run("rw_end");

    // Write entry 1 in the same cycle as its LOAD: old data wins
    do_start(2);
    wait_run("rbw_run");
    issue_done = 1'b1;
    tick();
    issue_done = 1'b0;
    tick();
    cfg_wr_en = 1'b1; cfg_wr_addr = 3'd1; cfg_wr_data = pack(200, 7, 0, 1);
    tick();
    cfg_wr_en = 1'b0;
    check("rbw_old_dim", 32'(issue_image_dim), 32'd80);
    complete_run("rbw_end");
    do_start(2);
    wait_run("rbw2_run");
    issue_done = 1'b1;
    tick();
    issue_done = 1'b0;
    tick(); tick();
    check("rbw_new_dim", 32'(issue_image_dim), 32'd200);
    complete_run("rbw2_end");

    // rst mid-run returns to IDLE but keeps the table
    do_start(1);
    wait_run("rstmid_run");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_dim", 32'(issue_image_dim), 32'd0);
    do_start(1);
    tick();
    check("rstmid_table", 32'(issue_image_dim), 32'd224);
    complete_run("rstmid_end");

`ifdef ISSUE_SEQ_PERF_EN
    // RUN lasts exactly 100 cycles
    do_start(1);
    wait_run("perf_run");
    for (int i = 0; i < 99; i++) tick();
    issue_done = 1'b1;
    tick();
    issue_done = 1'b0;
    check("perf_cycles", layer_cycles, 32'd100);
    check("perf_vld", 32'(layer_cycles_valid), 32'd1);
    tick();
    check("perf_vld_pulse", 32'(layer_cycles_valid), 32'd0);
    complete_run("perf_end");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
